// File: rtl/decode_stage_pkg.sv
// ----------------------------------------------------------------------------
// decode_stage_pkg : opcodes, ALU/immediate encodings, immediate extension
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package decode_stage_pkg;

  localparam int REG_AW = 5;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10
  } imm_src_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic     reg_write;
    logic     alu_src;
    logic     mem_write;
    logic     result_src;
    logic     branch;
    imm_src_e imm_src;
    alu_op_e  alu_op;
  } ctrl_t;

  function automatic logic [31:0] imm_extend(input logic [31:0] instr, input imm_src_e src);
    logic [31:0] imm;
    case (src)
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      default: imm = {{20{instr[31]}}, instr[31:20]};
    endcase
    return imm;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_stage_register_file.sv
// ----------------------------------------------------------------------------
// register_file : 2R/1W architectural registers, x0 = 0, write-through bypass
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module register_file #(
  parameter int NREGS = 32,
  parameter int XLEN  = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_en;

  assign wr_en = we && (waddr != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  // WB and ID share a cycle, so an in-flight write is forwarded to the reader.
  always_comb begin
    rdata1 = regs[raddr1];
    if (raddr1 == '0)                   rdata1 = '0;
    else if (wr_en && waddr == raddr1)  rdata1 = wdata;
  end

  always_comb begin
    rdata2 = regs[raddr2];
    if (raddr2 == '0)                   rdata2 = '0;
    else if (wr_en && waddr == raddr2)  rdata2 = wdata;
  end

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ----------------------------------------------------------------------------
// decode_stage : RV32I-subset ID stage with register file and ID/EX register
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int XLEN  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       InstrD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RDW,
  input  logic [XLEN-1:0]   ResultW,
  input  logic              FlushE,
  output logic              RegWriteE,
  output logic              ALUSrcE,
  output logic              MemWriteE,
  output logic              ResultSrcE,
  output logic              BranchE,
  output logic [2:0]        ALUControlE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [REG_AW-1:0] RS1E,
  output logic [REG_AW-1:0] RS2E,
  output logic [REG_AW-1:0] RDE
);

  logic [6:0]      op;
  logic [2:0]      funct3;
  logic            funct7_5;
  ctrl_t           ctrl;
  alu_ctrl_e       alu_ctrl;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic [XLEN-1:0] imm_ext;

  assign op       = InstrD[6:0];
  assign funct3   = InstrD[14:12];
  assign funct7_5 = InstrD[30];

  register_file #(
    .NREGS (NREGS),
    .XLEN  (XLEN),
    .AW    (REG_AW)
  ) u_register_file (
    .clk    (clk),
    .rst    (rst),
    .we     (RegWriteW),
    .waddr  (RDW),
    .wdata  (ResultW),
    .raddr1 (InstrD[19:15]),
    .raddr2 (InstrD[24:20]),
    .rdata1 (rd1),
    .rdata2 (rd2)
  );

  // Unknown opcodes fall through the defaults and become a bubble.
  always_comb begin
    ctrl         = '0;
    ctrl.imm_src = IMM_I;
    ctrl.alu_op  = ALUOP_ADD;
    case (op)
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.imm_src   = IMM_S;
      end
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_ITYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_BEQ: begin
        ctrl.branch  = 1'b1;
        ctrl.imm_src = IMM_B;
        ctrl.alu_op  = ALUOP_SUB;
      end
      default: ;
    endcase
  end

  // funct7[5] only selects sub for R-type; addi with a negative immediate stays add.
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (ctrl.alu_op)
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_ctrl = (op[5] && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

  assign imm_ext = imm_extend(InstrD, ctrl.imm_src);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || FlushE) begin
      RegWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      MemWriteE   <= 1'b0;
      ResultSrcE  <= 1'b0;
      BranchE     <= 1'b0;
      ALUControlE <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      RS1E        <= '0;
      RS2E        <= '0;
      RDE         <= '0;
    end else begin
      RegWriteE   <= ctrl.reg_write;
      ALUSrcE     <= ctrl.alu_src;
      MemWriteE   <= ctrl.mem_write;
      ResultSrcE  <= ctrl.result_src;
      BranchE     <= ctrl.branch;
      ALUControlE <= alu_ctrl;
      RD1E        <= rd1;
      RD2E        <= rd2;
      ImmExtE     <= imm_ext;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      RS1E        <= InstrD[19:15];
      RS2E        <= InstrD[24:20];
      RDE         <= InstrD[11:7];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ----------------------------------------------------------------------------
// tb_decode_stage : directed vector table plus randomized model comparison
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] InstrD = '0, PCD = '0, PCPlus4D = '0, ResultW = '0;
  logic        RegWriteW = 1'b0, FlushE = 1'b0;
  logic [4:0]  RDW = '0;
  logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  RS1E, RS2E, RDE;

  int checks = 0;
  int errors = 0;
  logic [31:0] mregs [32];

  decode_stage dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RS1E(RS1E), .RS2E(RS2E), .RDE(RDE)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // {RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, ALUControl[2:0]}
  function automatic logic [7:0] act_ctrl();
    return {RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model, derived from the instruction-class rules.
  function automatic logic [7:0] model_ctrl(input logic [31:0] ins);
    logic lw, sw, rt, it, bq;
    logic [2:0] alu;
    lw = ins[6:0] == 7'h03;
    sw = ins[6:0] == 7'h23;
    rt = ins[6:0] == 7'h33;
    it = ins[6:0] == 7'h13;
    bq = ins[6:0] == 7'h63;
    alu = 3'd0;
    if (bq) alu = 3'd1;
    else if (rt || it) begin
      case (ins[14:12])
        3'd0: alu = (rt && ins[30]) ? 3'd1 : 3'd0;
        3'd2: alu = 3'd5;
        3'd6: alu = 3'd3;
        3'd7: alu = 3'd2;
        default: alu = 3'd0;
      endcase
    end
    return {lw | rt | it, lw | sw | it, sw, lw, bq, alu};
  endfunction

  function automatic logic imm_valid(input logic [31:0] ins);
    return ins[6:0] inside {7'h03, 7'h23, 7'h13, 7'h63};
  endfunction

  function automatic logic [31:0] model_imm(input logic [31:0] ins);
    int v;
    case (ins[6:0])
      7'h23: v = ($signed(ins) >>> 25) * 32 + int'(ins[11:7]);
      7'h63: v = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      default: v = $signed(ins) >>> 20;
    endcase
    return 32'(v);
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] a, input logic wen,
                                        input logic [4:0] rdw, input logic [31:0] res);
    if (a == 0) return 32'd0;
    if (wen && rdw == a) return res;
    return mregs[a];
  endfunction

  task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic wen,
                      input logic [4:0] rdw, input logic [31:0] res, input logic fl);
    InstrD = ins; PCD = pc; PCPlus4D = pc + 32'd4;
    RegWriteW = wen; RDW = rdw; ResultW = res; FlushE = fl;
    @(posedge clk);
    if (wen && rdw != 0) mregs[rdw] = res;
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " ctrl"}, {24'd0, act_ctrl()}, 32'd0);
    chk({nm, " rd1"}, RD1E, 32'd0);
    chk({nm, " rd2"}, RD2E, 32'd0);
    chk({nm, " imm"}, ImmExtE, 32'd0);
    chk({nm, " pc"}, PCE | PCPlus4E, 32'd0);
    chk({nm, " regs"}, {17'd0, RS1E, RS2E, RDE}, 32'd0);
  endtask

  task automatic read_all_zero(input string nm);
    for (int a = 1; a < 32; a++) begin
      step({12'd0, 5'(a), 3'd0, 5'd1, 7'h33}, 32'h200, 1'b0, 5'd0, 32'd0, 1'b0);
      chk($sformatf("%s x%0d", nm, a), RD1E, 32'd0);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic        wen;
    logic [4:0]  rdw;
    logic [31:0] res;
    logic        flush;
    logic [7:0]  ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic        chk_imm;
    logic [4:0]  rd;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [31:0] ins, res, pc, e_rd1, e_rd2;
    logic [7:0]  e_ctrl;
    logic        wen, fl;
    logic [4:0]  rdw;

    tbl[0]  = '{32'h000281B3, 1, 5'd5, 32'hDEADBEEF, 0, 8'h80, 32'hDEADBEEF, 0, 0, 0, 5'd3};
    tbl[1]  = '{32'h000281B3, 0, 5'd0, 32'h0,        0, 8'h80, 32'hDEADBEEF, 0, 0, 0, 5'd3};
    tbl[2]  = '{32'h000000B3, 1, 5'd0, 32'h1234,     0, 8'h80, 0, 0, 0, 0, 5'd1};
    tbl[3]  = '{32'h000000B3, 0, 5'd0, 32'h0,        0, 8'h80, 0, 0, 0, 0, 5'd1};
    tbl[4]  = '{32'hFFC12083, 0, 5'd0, 32'h0,        0, 8'hD0, 0, 0, 32'hFFFFFFFC, 1, 5'd1};
    tbl[5]  = '{32'h0064A423, 0, 5'd0, 32'h0,        0, 8'h60, 0, 0, 32'h8, 1, 5'd8};
    tbl[6]  = '{32'hFE420CE3, 0, 5'd0, 32'h0,        0, 8'h09, 0, 0, 32'hFFFFFFF8, 1, 5'd25};
    tbl[7]  = '{32'h403100B3, 0, 5'd0, 32'h0,        0, 8'h81, 0, 0, 0, 0, 5'd1};
    tbl[8]  = '{32'h003120B3, 0, 5'd0, 32'h0,        0, 8'h85, 0, 0, 0, 0, 5'd1};
    tbl[9]  = '{32'h003160B3, 0, 5'd0, 32'h0,        0, 8'h83, 0, 0, 0, 0, 5'd1};
    tbl[10] = '{32'h003170B3, 0, 5'd0, 32'h0,        0, 8'h82, 0, 0, 0, 0, 5'd1};
    tbl[11] = '{32'hFFF00093, 0, 5'd0, 32'h0,        0, 8'hC0, 0, 0, 32'hFFFFFFFF, 1, 5'd1};
    tbl[12] = '{32'hFFC12083, 1, 5'd7, 32'h0000ABCD, 1, 8'h00, 0, 0, 0, 1, 5'd0};
    tbl[13] = '{32'h000380B3, 0, 5'd0, 32'h0,        0, 8'h80, 32'h0000ABCD, 0, 0, 0, 5'd1};
    tbl[14] = '{32'h0000007F, 0, 5'd0, 32'h0,        0, 8'h00, 0, 0, 0, 0, 5'd0};

    for (int r = 0; r < 32; r++) mregs[r] = 32'd0;

    // Reset held with random inputs toggling across edges.
    for (int c = 0; c < 3; c++) begin
      InstrD = $urandom; PCD = $urandom; PCPlus4D = $urandom;
      RegWriteW = 1'b1; RDW = 5'($urandom); ResultW = $urandom; FlushE = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    chk_all_zero("reset");
    RegWriteW = 1'b0;
    rst = 1'b1;
    read_all_zero("post-reset read");

    for (int i = 0; i < 15; i++) begin
      pc = 32'h1000 + 32'(i) * 4;
      step(tbl[i].instr, pc, tbl[i].wen, tbl[i].rdw, tbl[i].res, tbl[i].flush);
      chk($sformatf("vec%0d ctrl", i), {24'd0, act_ctrl()}, {24'd0, tbl[i].ctrl});
      chk($sformatf("vec%0d rd1", i), RD1E, tbl[i].rd1);
      chk($sformatf("vec%0d rd2", i), RD2E, tbl[i].rd2);
      chk($sformatf("vec%0d rde", i), {27'd0, RDE}, {27'd0, tbl[i].rd});
      chk($sformatf("vec%0d pce", i), PCE, tbl[i].flush ? 32'd0 : pc);
      if (tbl[i].chk_imm) chk($sformatf("vec%0d imm", i), ImmExtE, tbl[i].imm);
    end

    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      case ($urandom_range(0, 5))
        0: ins[6:0] = 7'h03;
        1: ins[6:0] = 7'h23;
        2: begin ins[6:0] = 7'h33; ins[31:25] = ($urandom % 2) ? 7'h20 : 7'h00; end
        3: ins[6:0] = 7'h13;
        4: ins[6:0] = 7'h63;
        default: ;
      endcase
      wen = 1'($urandom);
      rdw = ($urandom % 3 == 0) ? ins[19:15] : 5'($urandom);
      res = $urandom;
      fl  = ($urandom % 10) == 0;
      pc  = $urandom & 32'hFFFF_FFFC;
      e_ctrl = fl ? 8'd0 : model_ctrl(ins);
      e_rd1  = fl ? 32'd0 : mread(ins[19:15], wen, rdw, res);
      e_rd2  = fl ? 32'd0 : mread(ins[24:20], wen, rdw, res);
      step(ins, pc, wen, rdw, res, fl);
      chk($sformatf("rnd%0d ctrl ins=%h", n, ins), {24'd0, act_ctrl()}, {24'd0, e_ctrl});
      chk($sformatf("rnd%0d rd1", n), RD1E, e_rd1);
      chk($sformatf("rnd%0d rd2", n), RD2E, e_rd2);
      chk($sformatf("rnd%0d fields", n), {17'd0, RS1E, RS2E, RDE},
          fl ? 32'd0 : {17'd0, ins[19:15], ins[24:20], ins[11:7]});
      chk($sformatf("rnd%0d pc", n), PCE, fl ? 32'd0 : pc);
      chk($sformatf("rnd%0d pc4", n), PCPlus4E, fl ? 32'd0 : pc + 32'd4);
      if (fl || imm_valid(ins))
        chk($sformatf("rnd%0d imm ins=%h", n, ins), ImmExtE, fl ? 32'd0 : model_imm(ins));
    end

    // Asynchronous reset mid-operation: a valid lw is loaded, then reset between edges.
    step(32'hFFC12083, 32'h40, 1'b1, 5'd2, 32'h55AA55AA, 1'b0);
    #2 rst = 1'b0;
    #1 chk_all_zero("async reset");
    for (int r = 0; r < 32; r++) mregs[r] = 32'd0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    read_all_zero("mid-reset read");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
